cordic_job_arbiter: RTL and testbench
=====================================

CORDIC_JOB_ARBITER -- requirements
Module: cordic_job_arbiter

Interface
REQ-001 SHALL have parameter DATA_W, default 32, operand/result word width.
REQ-002 SHALL have parameter FIFO_DEPTH, default 32, power of two; result-FIFO and tag-FIFO depth, and also the maximum number of outstanding jobs.
REQ-003 ACLK  input  1  sole clock; all logic on the rising edge.
REQ-004 ARESETN  input  1  reset, asynchronous and active-low.
REQ-005 enable  input  1  high = new jobs may be issued.
REQ-006 s0_tvalid / s0_tready / s0_tdata  in / out / in  1 / 1 / DATA_W  requester 0 job stream.
REQ-007 s1_tvalid / s1_tready / s1_tdata  in / out / in  1 / 1 / DATA_W  requester 1 job stream.
REQ-008 core_in_valid / core_in_data  out / out  1 / DATA_W  issue to the shared CORDIC core; the core has no backpressure.
REQ-009 core_out_valid / core_out_data  in / in  1 / DATA_W  in-order results from the core, any latency.
REQ-010 m_tvalid / m_tready / m_tdata / m_tid  out / in / out / out  1 / 1 / DATA_W / 1  result stream; m_tid names the originating requester.
REQ-011 busy  output  1  work is in flight or pending.
REQ-012 err  output  1  sticky protocol-error flag.

Function
REQ-013 Credit count = tag-FIFO count + result-FIFO count.
REQ-014 issue_ok SHALL be: enable high AND credit count < FIFO_DEPTH.
REQ-015 Arbitration SHALL be round-robin over valid requesters:
- Only one requester valid: grant that requester.
- Both valid: grant the requester other than last_grant.
- last_grant updates only on a completed handshake.
REQ-016 sX_tready SHALL be high only when issue_ok is high and requester X is granted. It is combinational from valids, enable and counts. At most one handshake occurs per cycle.
REQ-017 On a handshake:
- the granted ID is pushed into the tag FIFO in the same cycle;
- core_in_valid=1 and core_in_data=granted tdata are registered, appearing for exactly one cycle on the next edge.
REQ-018 On core_out_valid:
- pop the tag FIFO;
- push {tag, core_out_data} into the result FIFO in the same cycle.
REQ-019 The result FIFO SHALL be first-word-fall-through.
- m_tvalid = not empty.
- m_tdata and m_tid come from the head entry.
- The head pops when m_tvalid and m_tready are both high.
REQ-020 A simultaneous push and pop on either FIFO SHALL leave its count unchanged. Pointers wrap modulo FIFO_DEPTH.
REQ-021 A handshake, a core result and an m-stream pop in the same cycle SHALL all be honoured, with net credit count +1-1.
REQ-022 If core_out_valid arrives with the tag FIFO empty, or with the result FIFO full, the result SHALL be dropped, err SHALL set and hold until reset, and FIFO state SHALL stay unchanged.
REQ-023 When enable falls:
- issuing stops the next cycle;
- in-flight jobs still complete and drain to the m stream.
REQ-024 busy SHALL be: core_in_valid OR tag FIFO non-empty OR result FIFO non-empty.
REQ-025 Results SHALL leave in issue order. No reordering between requesters.

Reset
REQ-026 While ARESETN is low, SHALL hold: s0_tready=s1_tready=0, core_in_valid=0, core_in_data=0, m_tvalid=0, m_tdata=0, m_tid=0, busy=0, err=0.
REQ-027 Reset SHALL clear both FIFOs and set last_grant=1, so requester 0 wins the first contested grant.
REQ-028 Reset asserted mid-operation SHALL discard all in-flight tags and results. Core results arriving after reset release SHALL then raise err per REQ-022.
REQ-029 Outputs SHALL first change on the first ACLK edge after ARESETN deasserts.

Verification
REQ-030 Both requesters valid continuously (s0 data 0x100+n, s1 data 0x200+n), enable=1, core latency 16, m_tready=1 -> core_in_data alternates 0x100,0x200,0x101,0x201…; m_tid alternates 0,1 with matching data.
REQ-031 Only s1 valid for 5 jobs -> 5 back-to-back handshakes, all m_tid=1; then s0 and s1 valid together -> s0 granted first.
REQ-032 m_tready=0, continuous requests -> exactly 32 handshakes, then sX_tready stays 0 and m_tvalid=1. Raise m_tready for 1 cycle -> exactly one further handshake.
REQ-033 enable dropped after 10 issues with latency 16 -> no further core_in_valid; all 10 results are delivered; busy falls the cycle after the last m pop.
REQ-034 core_out_valid pulsed with no job issued -> err=1 and m_tvalid stays 0; err is cleared only by ARESETN low.
REQ-035 ARESETN pulsed low with 4 jobs in flight -> all outputs reach reset values immediately (asynchronously); after release, the 4 stale core results each assert err and produce no m_tvalid.

Source files
------------

// File: rtl/cordic_job_arbiter.sv
// Round-robin arbiter that feeds two job streams into one shared CORDIC core
// and returns the in-order results, tagged with their requester, on one stream.
module cordic_job_arbiter #(
    parameter int DATA_W     = 32,
    parameter int FIFO_DEPTH = 32
) (
    input  logic              ACLK,
    input  logic              ARESETN,
    input  logic              enable,
    input  logic              s0_tvalid,
    output logic              s0_tready,
    input  logic [DATA_W-1:0] s0_tdata,
    input  logic              s1_tvalid,
    output logic              s1_tready,
    input  logic [DATA_W-1:0] s1_tdata,
    output logic              core_in_valid,
    output logic [DATA_W-1:0] core_in_data,
    input  logic              core_out_valid,
    input  logic [DATA_W-1:0] core_out_data,
    output logic              m_tvalid,
    input  logic              m_tready,
    output logic [DATA_W-1:0] m_tdata,
    output logic              m_tid,
    output logic              busy,
    output logic              err
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C  = CW'(FIFO_DEPTH);
    localparam logic [CW:0]   DEPTH_CR = (CW + 1)'(FIFO_DEPTH);

    logic              run_r;
    logic              last_grant_r;
    logic              core_in_valid_r;
    logic [DATA_W-1:0] core_in_data_r;
    logic              err_r;

    logic              tag_mem_r [FIFO_DEPTH];
    logic [AW-1:0]     tag_wr_r;
    logic [AW-1:0]     tag_rd_r;
    logic [CW-1:0]     tag_cnt_r;

    logic [DATA_W:0]   res_mem_r [FIFO_DEPTH];
    logic [AW-1:0]     res_wr_r;
    logic [AW-1:0]     res_rd_r;
    logic [CW-1:0]     res_cnt_r;

    logic [CW:0]       credit_s;
    logic              issue_ok_s;
    logic              grant0_s;
    logic              grant1_s;
    logic              hs_s;
    logic [DATA_W-1:0] hs_data_s;
    logic              tag_empty_s;
    logic              res_empty_s;
    logic              res_full_s;
    logic              core_ok_s;
    logic              core_bad_s;
    logic              m_pop_s;
    logic [DATA_W:0]   res_head_s;

    // run_r keeps the ready outputs quiet until the first edge after reset release.
    assign credit_s    = {1'b0, tag_cnt_r} + {1'b0, res_cnt_r};
    assign issue_ok_s  = run_r & enable & (credit_s < DEPTH_CR);
    assign tag_empty_s = (tag_cnt_r == {CW{1'b0}});
    assign res_empty_s = (res_cnt_r == {CW{1'b0}});
    assign res_full_s  = (res_cnt_r == DEPTH_C);
    assign core_ok_s   = core_out_valid & ~tag_empty_s & ~res_full_s;
    assign core_bad_s  = core_out_valid & (tag_empty_s | res_full_s);
    assign m_pop_s     = ~res_empty_s & m_tready;
    assign res_head_s  = res_mem_r[res_rd_r];

    // Round-robin grant: a lone requester wins, a contested grant alternates.
    always_comb begin
        grant0_s = 1'b0;
        grant1_s = 1'b0;
        if (s0_tvalid && s1_tvalid) begin
            if (last_grant_r) begin
                grant0_s = 1'b1;
            end else begin
                grant1_s = 1'b1;
            end
        end else if (s0_tvalid) begin
            grant0_s = 1'b1;
        end else if (s1_tvalid) begin
            grant1_s = 1'b1;
        end else begin
            grant0_s = 1'b0;
            grant1_s = 1'b0;
        end
    end

    assign s0_tready = issue_ok_s & grant0_s;
    assign s1_tready = issue_ok_s & grant1_s;
    assign hs_s      = issue_ok_s & (grant0_s | grant1_s);
    assign hs_data_s = grant1_s ? s1_tdata : s0_tdata;

    // Issue register towards the core, grant history and sticky error.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            run_r           <= 1'b0;
            last_grant_r    <= 1'b1;
            core_in_valid_r <= 1'b0;
            core_in_data_r  <= {DATA_W{1'b0}};
            err_r           <= 1'b0;
        end else begin
            run_r           <= 1'b1;
            core_in_valid_r <= hs_s;
            if (hs_s) begin
                last_grant_r   <= grant1_s;
                core_in_data_r <= hs_data_s;
            end
            if (core_bad_s) begin
                err_r <= 1'b1;
            end
        end
    end

    // Tag FIFO: requester ID per outstanding job, popped as results return.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            tag_wr_r  <= {AW{1'b0}};
            tag_rd_r  <= {AW{1'b0}};
            tag_cnt_r <= {CW{1'b0}};
        end else begin
            if (hs_s) begin
                tag_wr_r <= tag_wr_r + AW'(1'b1);
            end
            if (core_ok_s) begin
                tag_rd_r <= tag_rd_r + AW'(1'b1);
            end
            case ({hs_s, core_ok_s})
                2'b10:   tag_cnt_r <= tag_cnt_r + CW'(1'b1);
                2'b01:   tag_cnt_r <= tag_cnt_r - CW'(1'b1);
                default: tag_cnt_r <= tag_cnt_r;
            endcase
        end
    end

    // Result FIFO pointers and occupancy; the head is presented fall-through.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            res_wr_r  <= {AW{1'b0}};
            res_rd_r  <= {AW{1'b0}};
            res_cnt_r <= {CW{1'b0}};
        end else begin
            if (core_ok_s) begin
                res_wr_r <= res_wr_r + AW'(1'b1);
            end
            if (m_pop_s) begin
                res_rd_r <= res_rd_r + AW'(1'b1);
            end
            case ({core_ok_s, m_pop_s})
                2'b10:   res_cnt_r <= res_cnt_r + CW'(1'b1);
                2'b01:   res_cnt_r <= res_cnt_r - CW'(1'b1);
                default: res_cnt_r <= res_cnt_r;
            endcase
        end
    end

    // FIFO storage; contents are only meaningful behind the counts.
    always_ff @(posedge ACLK) begin
        if (hs_s) begin
            tag_mem_r[tag_wr_r] <= grant1_s;
        end
        if (core_ok_s) begin
            res_mem_r[res_wr_r] <= {tag_mem_r[tag_rd_r], core_out_data};
        end
    end

    // Result stream outputs, forced to zero while the FIFO is empty.
    always_comb begin
        m_tdata = {DATA_W{1'b0}};
        m_tid   = 1'b0;
        if (res_empty_s) begin
            m_tdata = {DATA_W{1'b0}};
            m_tid   = 1'b0;
        end else begin
            m_tdata = res_head_s[DATA_W-1:0];
            m_tid   = res_head_s[DATA_W];
        end
    end

    assign m_tvalid      = ~res_empty_s;
    assign core_in_valid = core_in_valid_r;
    assign core_in_data  = core_in_data_r;
    assign err           = err_r;
    assign busy          = core_in_valid_r | ~tag_empty_s | ~res_empty_s;

endmodule

// File: tb/tb_cordic_job_arbiter.sv
// Directed bench for cordic_job_arbiter with a fixed-latency XOR core model.
module tb_cordic_job_arbiter;

    localparam int          LAT = 16;
    localparam logic [31:0] K   = 32'hA5A5_0000;

    logic        ACLK = 1'b0;
    logic        ARESETN = 1'b0;
    logic        enable = 1'b0;
    logic        s0_tvalid = 1'b0;
    logic        s0_tready;
    logic [31:0] s0_tdata = 32'h100;
    logic        s1_tvalid = 1'b0;
    logic        s1_tready;
    logic [31:0] s1_tdata = 32'h200;
    logic        core_in_valid;
    logic [31:0] core_in_data;
    logic        core_out_valid;
    logic [31:0] core_out_data;
    logic        m_tvalid;
    logic        m_tready = 1'b0;
    logic [31:0] m_tdata;
    logic        m_tid;
    logic        busy;
    logic        err;

    int checks = 0;
    int errors = 0;
    int n0 = 0;
    int n1 = 0;
    int hs_cnt = 0;
    int hs_base = 0;
    int mv_cnt = 0;
    logic [31:0] ci_q[$];
    logic [32:0] mo_q[$];

    logic [LAT-1:0] pv = '0;
    logic [31:0]    pd [LAT];
    logic           inj_v = 1'b0;

    cordic_job_arbiter dut (
        .ACLK(ACLK), .ARESETN(ARESETN), .enable(enable),
        .s0_tvalid(s0_tvalid), .s0_tready(s0_tready), .s0_tdata(s0_tdata),
        .s1_tvalid(s1_tvalid), .s1_tready(s1_tready), .s1_tdata(s1_tdata),
        .core_in_valid(core_in_valid), .core_in_data(core_in_data),
        .core_out_valid(core_out_valid), .core_out_data(core_out_data),
        .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tdata(m_tdata), .m_tid(m_tid),
        .busy(busy), .err(err)
    );

    always #5 ACLK = ~ACLK;

    assign core_out_valid = pv[LAT-1] | inj_v;
    assign core_out_data  = pd[LAT-1] ^ K;

    // Core model and transaction logging.
    always @(posedge ACLK) begin
        pv    <= {pv[LAT-2:0], core_in_valid};
        pd[0] <= core_in_data;
        for (int i = 1; i < LAT; i++) pd[i] <= pd[i-1];
        if (s0_tvalid && s0_tready) n0 <= n0 + 1;
        if (s1_tvalid && s1_tready) n1 <= n1 + 1;
        hs_cnt <= hs_cnt + int'(s0_tvalid && s0_tready) + int'(s1_tvalid && s1_tready);
        if (core_in_valid) ci_q.push_back(core_in_data);
        if (m_tvalid && m_tready) mo_q.push_back({m_tid, m_tdata});
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge ACLK);
        #1;
        s0_tdata = 32'h100 + 32'(n0);
        s1_tdata = 32'h200 + 32'(n1);
    endtask

    function automatic logic [63:0] mo_at(input int k);
        if (k < mo_q.size()) return {31'd0, mo_q[k]};
        return 64'hDEAD_DEAD_DEAD_DEAD;
    endfunction

    function automatic logic [63:0] ci_at(input int k);
        if (k < ci_q.size()) return {32'd0, ci_q[k]};
        return 64'hDEAD_DEAD_DEAD_DEAD;
    endfunction

    logic [31:0] exp_ci [8] = '{32'h100, 32'h200, 32'h101, 32'h201,
                                32'h102, 32'h202, 32'h103, 32'h203};

    initial begin
        for (int i = 0; i < LAT; i++) pd[i] = 32'h0;

        // Reset values while ARESETN is held low, with a requester pending.
        enable = 1'b1;
        s0_tvalid = 1'b1;
        @(negedge ACLK);
        check("rst_s0_tready", 64'(s0_tready), 64'd0);
        check("rst_core_in_valid", 64'(core_in_valid), 64'd0);
        check("rst_core_in_data", 64'(core_in_data), 64'd0);
        check("rst_m_tvalid", 64'(m_tvalid), 64'd0);
        check("rst_m_tdata", 64'(m_tdata), 64'd0);
        check("rst_m_tid", 64'(m_tid), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_err", 64'(err), 64'd0);
        @(negedge ACLK);
        ARESETN = 1'b1;
        #2;
        check("release_no_ready_before_edge", 64'(s0_tready), 64'd0);
        s0_tvalid = 1'b0;
        tick();

        // Both requesters continuously valid: strict alternation, s0 first.
        s0_tvalid = 1'b1;
        s1_tvalid = 1'b1;
        m_tready  = 1'b1;
        for (int i = 0; i < 50 && (n0 + n1) < 8; i++) tick();
        s0_tvalid = 1'b0;
        s1_tvalid = 1'b0;
        for (int i = 0; i < 100 && mo_q.size() < 8; i++) tick();
        check("rr_result_count", 64'(mo_q.size()), 64'd8);
        for (int k = 0; k < 8; k++) begin
            check("rr_core_in_data", ci_at(k), {32'd0, exp_ci[k]});
            check("rr_m_out", mo_at(k), {31'd0, (k % 2 == 1), exp_ci[k] ^ K});
        end

        // Lone requester 1 gets back-to-back grants, then s0 wins the contest.
        ci_q.delete();
        mo_q.delete();
        s1_tvalid = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge ACLK);
            check("s1_only_ready", 64'(s1_tready), 64'd1);
            tick();
        end
        s0_tvalid = 1'b1;
        @(negedge ACLK);
        check("contest_s0_ready", 64'(s0_tready), 64'd1);
        check("contest_s1_ready", 64'(s1_tready), 64'd0);
        tick();
        s0_tvalid = 1'b0;
        s1_tvalid = 1'b0;
        for (int i = 0; i < 100 && mo_q.size() < 6; i++) tick();
        check("s1_only_first", mo_at(0), {31'd0, 1'b1, 32'h204 ^ K});
        check("s1_only_fifth", mo_at(4), {31'd0, 1'b1, 32'h208 ^ K});
        check("contest_result", mo_at(5), {31'd0, 1'b0, 32'h104 ^ K});

        // Sink stalled: credit limit of 32 outstanding, then one pop frees one slot.
        ci_q.delete();
        mo_q.delete();
        hs_base = hs_cnt;
        m_tready = 1'b0;
        s0_tvalid = 1'b1;
        s1_tvalid = 1'b1;
        for (int i = 0; i < 80; i++) tick();
        check("stall_handshakes", 64'(hs_cnt - hs_base), 64'd32);
        @(negedge ACLK);
        check("stall_s0_ready", 64'(s0_tready), 64'd0);
        check("stall_s1_ready", 64'(s1_tready), 64'd0);
        check("stall_m_tvalid", 64'(m_tvalid), 64'd1);
        check("stall_head", {31'd0, m_tid, m_tdata}, {31'd0, 1'b1, 32'h209 ^ K});
        tick();
        m_tready = 1'b1;
        tick();
        m_tready = 1'b0;
        for (int i = 0; i < 40; i++) tick();
        check("stall_one_more", 64'(hs_cnt - hs_base), 64'd33);
        check("stall_one_pop", 64'(mo_q.size()), 64'd1);
        s0_tvalid = 1'b0;
        s1_tvalid = 1'b0;
        m_tready  = 1'b1;
        for (int i = 0; i < 200 && (busy || mo_q.size() < 33); i++) tick();
        check("stall_drain_count", 64'(mo_q.size()), 64'd33);
        check("stall_second", mo_at(1), {31'd0, 1'b0, 32'h105 ^ K});
        check("stall_last", mo_at(32), {31'd0, 1'b1, 32'h219 ^ K});

        // Enable dropped after ten issues: in-flight jobs still drain.
        ci_q.delete();
        mo_q.delete();
        hs_base = hs_cnt;
        s0_tvalid = 1'b1;
        for (int i = 0; i < 40 && (hs_cnt - hs_base) < 10; i++) tick();
        enable = 1'b0;
        @(negedge ACLK);
        check("disable_ready", 64'(s0_tready), 64'd0);
        for (int i = 0; i < 100 && mo_q.size() < 10; i++) @(negedge ACLK);
        check("disable_busy_after_last_pop", 64'(busy), 64'd0);
        check("disable_result_count", 64'(mo_q.size()), 64'd10);
        check("disable_issue_count", 64'(ci_q.size()), 64'd10);
        check("disable_first_issue", ci_at(0), 64'h115);
        check("disable_last_result", mo_at(9), {31'd0, 1'b0, 32'h11E ^ K});
        s0_tvalid = 1'b0;
        enable = 1'b1;

        // Spurious core result with nothing outstanding.
        tick();
        inj_v = 1'b1;
        tick();
        inj_v = 1'b0;
        @(negedge ACLK);
        check("spurious_err", 64'(err), 64'd1);
        check("spurious_m_tvalid", 64'(m_tvalid), 64'd0);
        for (int i = 0; i < 3; i++) tick();
        @(negedge ACLK);
        check("spurious_err_sticky", 64'(err), 64'd1);
        check("spurious_m_tvalid_later", 64'(m_tvalid), 64'd0);
        tick();
        ARESETN = 1'b0;
        #1;
        check("spurious_err_cleared", 64'(err), 64'd0);
        tick();
        ARESETN = 1'b1;
        tick();

        // Reset mid-flight with four jobs outstanding.
        hs_base = hs_cnt;
        s0_tvalid = 1'b1;
        for (int i = 0; i < 40 && (hs_cnt - hs_base) < 4; i++) tick();
        s0_tvalid = 1'b0;
        for (int i = 0; i < 3; i++) tick();
        @(negedge ACLK);
        check("inflight_busy", 64'(busy), 64'd1);
        s0_tvalid = 1'b1;
        #2;
        ARESETN = 1'b0;
        #1;
        check("async_rst_s0_tready", 64'(s0_tready), 64'd0);
        check("async_rst_busy", 64'(busy), 64'd0);
        check("async_rst_m_tvalid", 64'(m_tvalid), 64'd0);
        check("async_rst_core_in_valid", 64'(core_in_valid), 64'd0);
        check("async_rst_err", 64'(err), 64'd0);
        tick();
        s0_tvalid = 1'b0;
        ARESETN = 1'b1;
        @(negedge ACLK);
        check("post_rst_err_clear", 64'(err), 64'd0);
        for (int i = 0; i < 30; i++) begin
            @(negedge ACLK);
            if (m_tvalid) mv_cnt++;
        end
        check("stale_no_m_tvalid", 64'(mv_cnt), 64'd0);
        check("stale_err", 64'(err), 64'd1);
        check("stale_busy", 64'(busy), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
